// File: rtl/bsg_fifo_1r1w_rolly_spec.sv
// Two-sided speculative ("rolly") 1R1W FIFO with synchronous-read storage and a write-to-read bypass.
// Write-side speculation is compiled in only when BSG_FIFO_ROLLY_WSPEC_EN is defined.
module bsg_fifo_1r1w_rolly_spec #(
  parameter int width_p            = 8,
  parameter int lg_size_p          = 2,
  parameter bit ready_THEN_valid_p = 1'b0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clr_v_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic               w_commit_i,
  input  logic               w_roll_i,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i,
  input  logic               r_commit_i,
  input  logic               r_roll_i
);

  localparam int els_lp = 1 << lg_size_p;

  typedef logic [lg_size_p:0]   ptr_t;
  typedef logic [lg_size_p-1:0] addr_t;

  ptr_t wptr, wcptr, rptr, rcptr;
  ptr_t wptr_n, wcptr_n, rptr_n, rcptr_n;
  ptr_t wptr_inc, rptr_inc;

  logic full, empty, enq, bypass;
  logic w_commit, w_roll;

  logic [width_p-1:0] mem [els_lp];
  logic [width_p-1:0] mem_data_p1;
  logic [width_p-1:0] bypass_data_p1;
  logic               bypass_sel_p1;

`ifdef BSG_FIFO_ROLLY_WSPEC_EN
  assign w_commit = w_commit_i;
  assign w_roll   = w_roll_i;
`else
  // Every enqueue is implicitly committed; the write-side controls have no effect.
  logic unused_wspec;
  assign unused_wspec = w_commit_i ^ w_roll_i;
  assign w_commit     = 1'b0;
  assign w_roll       = 1'b0;
`endif

  // Occupancy is measured against the committed read pointer so that speculatively
  // dequeued entries stay reclaimable until the reader commits.
  assign full  = (ptr_t'(wptr - rcptr) == ptr_t'(els_lp));
  assign empty = (rptr == wcptr);

  assign ready_o = ~reset_i & ~clr_v_i & ~w_roll & ~full;
  assign v_o     = ~reset_i & ~clr_v_i & ~r_roll_i & ~empty;
  assign enq     = v_i & (ready_o | ready_THEN_valid_p);

  assign wptr_inc = wptr + ptr_t'(enq);
  assign rptr_inc = rptr + ptr_t'(yumi_i);

  always_comb begin
    wptr_n  = wptr_inc;
    wcptr_n = wcptr;
    if (clr_v_i) begin
      wptr_n  = '0;
      wcptr_n = '0;
    end else begin
      if (w_roll) wptr_n = wcptr;
      if (w_commit & ~w_roll) wcptr_n = wptr_inc;
    end
`ifndef BSG_FIFO_ROLLY_WSPEC_EN
    wcptr_n = wptr_n;
`endif
  end

  always_comb begin
    rptr_n  = rptr_inc;
    rcptr_n = rcptr;
    if (clr_v_i) begin
      rptr_n  = '0;
      rcptr_n = '0;
    end else begin
      if (r_roll_i) rptr_n = rcptr;
      if (r_commit_i & ~r_roll_i) rcptr_n = rptr_inc;
    end
  end

  // A write landing on the slot about to be read cannot go through the memory,
  // which does not forward same-address writes, so it is steered around it.
  assign bypass = enq & (addr_t'(wptr) == addr_t'(rptr_n));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr          <= '0;
      wcptr         <= '0;
      rptr          <= '0;
      rcptr         <= '0;
      bypass_sel_p1 <= 1'b0;
    end else begin
      wptr          <= wptr_n;
      wcptr         <= wcptr_n;
      rptr          <= rptr_n;
      rcptr         <= rcptr_n;
      bypass_sel_p1 <= bypass;
    end
  end

  // Stage p1: synchronous memory read of the next head, or the bypassed write data.
  always_ff @(posedge clk_i) begin
    if (enq) mem[addr_t'(wptr)] <= data_i;
    if (bypass) bypass_data_p1 <= data_i;
    else        mem_data_p1    <= mem[addr_t'(rptr_n)];
  end

  assign data_o = bypass_sel_p1 ? bypass_data_p1 : mem_data_p1;

  always_ff @(posedge clk_i) begin
    if (!reset_i) assert (!yumi_i || v_o);
  end

endmodule

// File: tb/tb_bsg_fifo_1r1w_rolly_spec.sv
// Randomized scoreboard bench for bsg_fifo_1r1w_rolly_spec against a queue-level reference model.
// Follows BSG_FIFO_ROLLY_WSPEC_EN so the model matches whichever build is compiled.
module tb_bsg_fifo_1r1w_rolly_spec;

`ifdef BSG_FIFO_ROLLY_WSPEC_EN
  localparam bit wspec_en = 1'b1;
`else
  localparam bit wspec_en = 1'b0;
`endif
  localparam int els = 4;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1, clr_v_i = 1'b0, v_i = 1'b0, ready_o;
  logic       w_commit_i = 1'b0, w_roll_i = 1'b0, v_o, yumi_i = 1'b0;
  logic       r_commit_i = 1'b0, r_roll_i = 1'b0;
  logic [7:0] data_i = '0, data_o;

  bsg_fifo_1r1w_rolly_spec #(.width_p(8), .lg_size_p(2), .ready_THEN_valid_p(1'b0)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .clr_v_i(clr_v_i), .data_i(data_i), .v_i(v_i),
    .ready_o(ready_o), .w_commit_i(w_commit_i), .w_roll_i(w_roll_i), .data_o(data_o),
    .v_o(v_o), .yumi_i(yumi_i), .r_commit_i(r_commit_i), .r_roll_i(r_roll_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: committed-but-unreleased entries, uncommitted writes, and
  // the number of entries speculatively consumed from the front of vis.
  logic [7:0] vis[$];
  logic [7:0] wsp[$];
  int         roff = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit clr, input bit v, input logic [7:0] d,
                      input bit wc, input bit wr, input bit yq, input bit rc, input bit rr);
    bit m_ready, m_v, enq, y;
    logic [7:0] head;
    @(negedge clk_i);
    reset_i = rst; clr_v_i = clr; v_i = v; data_i = d;
    w_commit_i = wc; w_roll_i = wr; r_commit_i = rc; r_roll_i = rr; yumi_i = 1'b0;
    #1;
    m_ready = !rst && !clr && !(wspec_en && wr) && ((vis.size() + wsp.size()) < els);
    m_v     = !rst && !clr && !rr && (roff < vis.size());
    head    = m_v ? vis[roff] : 8'h00;
    chk("ready_o", int'(ready_o), int'(m_ready));
    chk("v_o", int'(v_o), int'(m_v));
    if (m_v && v_o) chk("data_o", int'(data_o), int'(head));
    y = yq && m_v && v_o;
    yumi_i = y;
    if (y) exp_q.push_back(head);
    enq = v && m_ready;
    if (rst || clr) begin
      vis.delete(); wsp.delete(); roff = 0;
    end else begin
      if (wspec_en) begin
        if (enq) wsp.push_back(d);
        if (wr) wsp.delete();
        else if (wc) begin
          foreach (wsp[i]) vis.push_back(wsp[i]);
          wsp.delete();
        end
      end else if (enq) begin
        vis.push_back(d);
      end
      if (rr) roff = 0;
      else begin
        roff += int'(y);
        if (rc) begin
          repeat (roff) void'(vis.pop_front());
          roff = 0;
        end
      end
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 8'h00, 0, 0, 0, 0, 0);
  endtask

  task automatic put(input logic [7:0] d, input bit wc);
    step(0, 0, 1, d, wc, 0, 0, 0, 0);
  endtask

  task automatic deq(input bit rc);
    step(0, 0, 0, 8'h00, 0, 0, 1, rc, 0);
  endtask

  // Monitor: consumes one expected entry per accepted dequeue.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk_i);
      #3;
      if (v_o && yumi_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL scoreboard_underflow: got 0x%0h expected none", data_o);
        end else begin
          e = exp_q.pop_front();
          chk("deq_data", int'(data_o), int'(e));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, then first cycle out of reset.
    step(1, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    step(1, 0, 1, 8'h55, 0, 0, 0, 0, 0);
    idle();

    // Uncommitted writes stay hidden until w_commit.
    put(8'h11, 0); put(8'h22, 0); idle(); idle();
    step(0, 0, 0, 8'h00, 1, 0, 0, 0, 0);
    idle();
    deq(1); deq(1); idle();
    step(0, 1, 0, 8'h00, 0, 0, 0, 0, 0);

    // Write roll discards the uncommitted tail; next enqueue reuses the slot.
    put(8'hA0, 1); put(8'hA1, 0);
    step(0, 0, 0, 8'h00, 0, 1, 0, 0, 0);
    deq(1); deq(1); deq(1);
    put(8'hB0, 1); deq(1); deq(1);
    step(0, 1, 0, 8'h00, 0, 0, 0, 0, 0);

    // Read replay and partial commit.
    put(8'h01, 1); put(8'h02, 1); put(8'h03, 1);
    deq(0); deq(0);
    step(0, 0, 0, 8'h00, 0, 0, 0, 0, 1);
    idle();
    deq(1); deq(0); deq(0); idle();
    step(0, 0, 0, 8'h00, 0, 0, 0, 0, 1);
    deq(0); deq(1); idle();
    step(0, 1, 0, 8'h00, 0, 0, 0, 0, 0);

    // Full, slots held until read commit, then wrap with ordered data.
    for (int i = 0; i < 5; i++) put(8'hC0 + 8'(i), 1);
    for (int i = 0; i < 4; i++) deq(0);
    put(8'hCF, 1); idle();
    step(0, 0, 0, 8'h00, 0, 0, 0, 1, 0);
    idle();
    for (int i = 0; i < 12; i++) step(0, 0, 1, 8'h40 + 8'(i), 1, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) deq(1);

    // Bypass: enqueue+commit into the slot being read, back to back with yumi.
    step(0, 1, 0, 8'h00, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 8'($urandom_range(0, 255)), 1, 0, 1, 1, 0);
    deq(1); deq(1); idle();

    // Clear and reset mid-flight with mixed speculation.
    for (int k = 0; k < 2; k++) begin
      put(8'hD1, 1); put(8'hD2, 1); put(8'hD3, 0); deq(0);
      step(k == 1, k == 0, 1, 8'hD4, 1, 0, 0, 0, 0);
      idle();
      for (int i = 0; i < 5; i++) put(8'hE0 + 8'(i), 1);
      for (int i = 0; i < 4; i++) deq(1);
      idle();
    end

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 79) == 0, $urandom_range(0, 1) == 1,
           8'($urandom_range(0, 255)), $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0);
    end

    idle(); idle();
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
